// File: rtl/mul_booth_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mul_booth_seq_pkg
//  Purpose  : Shared definitions for the radix-4 Booth sequencer.
//             - FSM state encoding (IDLE / BUSY / DONE)
//             - Booth triple codes {y[2i+1], y[2i], y[2i-1]}
//             - Default operand width
//  Revision : 1.0 - initial release
// ============================================================================
package mul_booth_seq_pkg;

    localparam int c_DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Booth triple codes and the multiple each one selects
    localparam logic [2:0] c_TRIPLE_Z0  = 3'b000; //  0
    localparam logic [2:0] c_TRIPLE_P1A = 3'b001; // +X
    localparam logic [2:0] c_TRIPLE_P1B = 3'b010; // +X
    localparam logic [2:0] c_TRIPLE_P2  = 3'b011; // +2X
    localparam logic [2:0] c_TRIPLE_M2  = 3'b100; // -2X
    localparam logic [2:0] c_TRIPLE_M1A = 3'b101; // -X
    localparam logic [2:0] c_TRIPLE_M1B = 3'b110; // -X
    localparam logic [2:0] c_TRIPLE_Z1  = 3'b111; //  0

endpackage : mul_booth_seq_pkg
`default_nettype wire

// File: rtl/mul_booth_seq_booth_sel.sv
`default_nettype none
// ============================================================================
//  Module   : booth_sel
//  Purpose  : Combinational radix-4 Booth partial-product selector.
//             Negative multiples are returned as the one's complement in pp
//             with neg=1; the consumer adds neg as a carry-in at the digit's
//             weight to complete the two's complement.
//  Ports    : x      in  W      multiplicand, already sign/zero extended
//             triple in  3      Booth triple {y[2i+1], y[2i], y[2i-1]}
//             pp     out W+1    selected multiple, sign-extended
//             neg    out 1      carry-in to complete negation
//  Revision : 1.0 - initial release
// ============================================================================
module booth_sel
    import mul_booth_seq_pkg::*;
#(
    parameter int W = 34
) (
    input  logic [W-1:0] x,
    input  logic [2:0]   triple,
    output logic [W:0]   pp,
    output logic         neg
);

    logic [W:0] w_x1;
    logic [W:0] w_x2;

    // x is a signed W-bit value, so 2x still fits in W+1 bits
    assign w_x1 = {x[W-1], x};
    assign w_x2 = {x, 1'b0};

    always_comb begin
        pp  = '0;
        neg = 1'b0;
        case (triple)
            c_TRIPLE_P1A, c_TRIPLE_P1B: pp = w_x1;
            c_TRIPLE_P2:                pp = w_x2;
            c_TRIPLE_M2: begin
                pp  = ~w_x2;
                neg = 1'b1;
            end
            c_TRIPLE_M1A, c_TRIPLE_M1B: begin
                pp  = ~w_x1;
                neg = 1'b1;
            end
            default: begin
                pp  = '0;
                neg = 1'b0;
            end
        endcase
    end

endmodule : booth_sel
`default_nettype wire

// File: rtl/mul_booth_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mul_booth_seq
//  Purpose  : Iterative radix-4 Booth multiplier. One operand pair accepted
//             over valid/ready, one Booth digit retired per cycle into a
//             wide accumulator, 2*WIDTH-bit product presented over
//             valid/ready. Supports flush of the in-flight operation.
//  Ports    : clk, rst                 clock, synchronous active-high reset
//             in_valid/in_ready        operand handshake
//             in1, in2                 multiplicand, multiplier
//             in1_signed, in2_signed   signedness of each operand
//             flush                    abort current op, discard result
//             out_valid/out_ready      product handshake
//             out                      low 2*WIDTH bits of exact product
//  Revision : 1.0 - initial release
// ============================================================================
module mul_booth_seq
    import mul_booth_seq_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    input  logic                 in1_signed,
    input  logic                 in2_signed,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out
);

    localparam int c_N  = WIDTH / 2 + 1;       // Booth digits per operation
    localparam int c_CW = $clog2(c_N);         // digit counter width
    localparam int c_XW = WIDTH + 2;           // extended operand width
    localparam int c_AW = 2 * WIDTH + 4;       // accumulator width
    localparam int c_SW = c_CW + 1;            // shift amount width (2*cnt)

    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(c_N - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
    localparam logic [c_AW-1:0] c_ACC_ONE  = c_AW'(1);

    state_t              r_state;
    state_t              w_state_next;
    logic [c_CW-1:0]     r_cnt;
    logic [c_XW-1:0]     r_x;
    // Multiplier with y[-1]=0 appended; shifted right two bits per digit so
    // the current triple always sits in bits [2:0].
    logic [c_XW:0]       r_y;
    logic [c_AW-1:0]     r_acc;
    logic [2*WIDTH-1:0]  r_out;

    logic [c_XW:0]       w_pp;
    logic                w_neg;
    logic [c_AW-1:0]     w_pp_ext;
    logic [c_SW-1:0]     w_shamt;
    logic [c_AW-1:0]     w_addend;
    logic [c_AW-1:0]     w_carry;
    logic [c_AW-1:0]     w_acc_next;
    logic                w_accept;
    logic                w_last;

    // ------------------------------------------------------------------
    // Partial product selection and accumulation
    // ------------------------------------------------------------------
    booth_sel #(
        .W (c_XW)
    ) u_booth_sel (
        .x      (r_x),
        .triple (r_y[2:0]),
        .pp     (w_pp),
        .neg    (w_neg)
    );

    assign w_pp_ext   = {{(c_AW - c_XW - 1){w_pp[c_XW]}}, w_pp};
    assign w_shamt    = {r_cnt, 1'b0};
    assign w_addend   = w_pp_ext << w_shamt;
    // Shifting ~v left leaves zeros below the digit weight, so the negation
    // carry must enter at that weight rather than at bit 0.
    assign w_carry    = w_neg ? (c_ACC_ONE << w_shamt) : '0;
    assign w_acc_next = r_acc + w_addend + w_carry;

    assign w_accept = (r_state == ST_IDLE) && in_valid && !flush;
    assign w_last   = (r_cnt == c_CNT_LAST);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_state_next = ST_BUSY;
            ST_BUSY: if (w_last)    w_state_next = ST_DONE;
            ST_DONE: if (out_ready) w_state_next = ST_IDLE;
            default:                w_state_next = ST_IDLE;
        endcase
        if (flush) begin
            w_state_next = ST_IDLE;
        end
    end

    // Handshake outputs are pure state decodes
    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign out       = r_out;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_x   <= '0;
            r_y   <= '0;
            r_acc <= '0;
            r_out <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_x   <= {{2{in1_signed & in1[WIDTH-1]}}, in1};
                r_y   <= {{2{in2_signed & in2[WIDTH-1]}}, in2, 1'b0};
                r_acc <= '0;
                r_cnt <= '0;
            end else if (r_state == ST_BUSY) begin
                r_acc <= w_acc_next;
                r_y   <= r_y >> 2;
                if (w_last) begin
                    r_cnt <= '0;
                    r_out <= w_acc_next[2*WIDTH-1:0];
                end else begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                end
            end
        end
    end

endmodule : mul_booth_seq
`default_nettype wire

// File: tb/tb_mul_booth_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_booth_seq
//  Purpose  : Self-checking directed bench for mul_booth_seq (WIDTH=32).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mul_booth_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        in1_signed;
    logic        in2_signed;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out;

    int checks   = 0;
    int failures = 0;

    mul_booth_seq #(
        .WIDTH (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in1        (in1),
        .in2        (in2),
        .in1_signed (in1_signed),
        .in2_signed (in2_signed),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic sa, input logic sb);
        logic signed [65:0] ea;
        logic signed [65:0] eb;
        logic signed [65:0] p;
        ea = {{34{sa & a[31]}}, a};
        eb = {{34{sb & b[31]}}, b};
        p  = ea * eb;
        return p[63:0];
    endfunction

    // One full operation. stall: cycles out_ready held low in DONE.
    // pulse: drive a stray in_valid mid-BUSY. chk_lat: verify latency.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sa, input logic sb, input logic [63:0] exp,
                          input int stall, input bit pulse, input bit chk_lat);
        int lat;
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        in1 = a; in2 = b; in1_signed = sa; in2_signed = sb; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (pulse && lat == 5) begin
                in1 = 32'd100; in2 = 32'd100; in_valid = 1'b1;
            end
            tick();
            in_valid = 1'b0;
            lat++;
        end
        if (chk_lat) check({tag, "_latency"}, 64'(lat), 64'd17);
        check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, "_out"}, out, exp);
        for (int s = 0; s < stall; s++) begin
            tick();
            check({tag, "_stall_out"}, out, exp);
            check({tag, "_stall_valid"}, {63'd0, out_valid}, 64'd1);
            check({tag, "_stall_in_ready"}, {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_post_in_ready"}, {63'd0, in_ready}, 64'd1);
        check({tag, "_post_out_valid"}, {63'd0, out_valid}, 64'd0);
    endtask

    // Start an op, then abort it after 8 BUSY edges with flush or rst.
    task automatic abort_op(input string tag, input bit use_rst);
        bit seen;
        in1 = 32'd9; in2 = 32'd9; in1_signed = 1'b0; in2_signed = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b0;
        check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        if (use_rst) check({tag, "_out_cleared"}, out, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check({tag, "_never_valid"}, {63'd0, seen}, 64'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rsa;
        logic        rsb;
        bit          seen;

        rst = 1'b1; in_valid = 1'b0; in1 = '0; in2 = '0;
        in1_signed = 1'b0; in2_signed = 1'b0; flush = 1'b0; out_ready = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_out", out, 64'd0);

        run_op("uu_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0,
               64'hFFFF_FFFE_0000_0001, 0, 1'b0, 1'b1);
        run_op("ss_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1,
               64'h0000_0000_0000_0001, 0, 1'b0, 1'b1);
        run_op("ss_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1,
               64'h4000_0000_0000_0000, 0, 1'b0, 1'b0);
        run_op("su_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0,
               64'hFFFF_FFFF_0000_0001, 0, 1'b0, 1'b0);
        run_op("uu_msb2", 32'h8000_0000, 32'h0000_0002, 1'b0, 1'b0,
               64'h0000_0001_0000_0000, 0, 1'b0, 1'b0);
        run_op("us_neg", 32'h0000_0003, 32'hFFFF_FFFB, 1'b0, 1'b1,
               64'hFFFF_FFFF_FFFF_FFF1, 0, 1'b0, 1'b0);

        run_op("bp_7x6", 32'd7, 32'd6, 1'b0, 1'b0, 64'd42, 5, 1'b1, 1'b1);

        abort_op("flush", 1'b0);
        run_op("after_flush", 32'd3, 32'd5, 1'b1, 1'b1, 64'd15, 0, 1'b0, 1'b1);
        abort_op("rst_mid", 1'b1);
        run_op("after_rst", 32'd3, 32'd5, 1'b1, 1'b1, 64'd15, 0, 1'b0, 1'b1);

        // flush with in_valid in IDLE: no accept
        in1 = 32'd4; in2 = 32'd4; in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        check("flush_idle_in_ready", {63'd0, in_ready}, 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("flush_idle_no_result", {63'd0, seen}, 64'd0);

        for (int n = 0; n < 300; n++) begin
            ra  = $urandom;
            rb  = $urandom;
            rsa = 1'($urandom_range(0, 1));
            rsb = 1'($urandom_range(0, 1));
            if (n % 16 == 0) ra = 32'h8000_0000;
            if (n % 16 == 1) rb = 32'h7FFF_FFFF;
            run_op("rand", ra, rb, rsa, rsb, model(ra, rb, rsa, rsb),
                   $urandom_range(0, 2), 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mul_booth_seq
`default_nettype wire
